// File: rtl/avl_arbiter.sv
// Two-port arbiter: instruction fetch and data load/store share one single-outstanding Avalon bridge.
// Requests are latched, granted one at a time, and the bridge response is routed back to the winner.
module avl_arbiter #(
    parameter int unsigned PRIORITY_MODE = 0
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        i_valid,
    input  logic [31:0] i_addr,
    output logic [31:0] i_rdata,
    output logic        i_ready,
    input  logic        d_valid,
    input  logic [31:0] d_addr,
    input  logic [31:0] d_wdata,
    input  logic [3:0]  d_wstrb,
    output logic [31:0] d_rdata,
    output logic        d_ready,
    output logic        avl_valid,
    output logic        avl_instr,
    output logic [31:0] avl_addr,
    output logic [31:0] avl_wdata,
    output logic [3:0]  avl_wstrb,
    input  logic [31:0] avl_rdata,
    input  logic        avl_ready
);

    typedef enum logic {StIdle, StBusy} state_t;

    state_t      r_state;
    state_t      w_state_next;

    logic        r_pend_i;
    logic        r_pend_d;
    logic [31:0] r_i_addr;
    logic [31:0] r_d_addr;
    logic [31:0] r_d_wdata;
    logic [3:0]  r_d_wstrb;
    logic        r_last_data;

    logic        r_avl_valid;
    logic        r_avl_instr;
    logic [31:0] r_avl_addr;
    logic [31:0] r_avl_wdata;
    logic [3:0]  r_avl_wstrb;

    logic        r_i_ready;
    logic        r_d_ready;
    logic [31:0] r_i_rdata;
    logic [31:0] r_d_rdata;

    logic        w_grant_i;
    logic        w_grant_d;
    logic        w_complete;
    logic        w_cap_i;
    logic        w_cap_d;

    always_comb begin
        w_state_next = r_state;
        w_grant_i    = 1'b0;
        w_grant_d    = 1'b0;
        w_complete   = 1'b0;
        case (r_state)
            StIdle: begin
                if (r_pend_i && r_pend_d) begin
                    // Round-robin hands the tie to whichever port did not win last time.
                    if (PRIORITY_MODE != 0 || !r_last_data) begin
                        w_grant_d = 1'b1;
                    end else begin
                        w_grant_i = 1'b1;
                    end
                end else if (r_pend_i) begin
                    w_grant_i = 1'b1;
                end else if (r_pend_d) begin
                    w_grant_d = 1'b1;
                end
                if (r_pend_i || r_pend_d) begin
                    w_state_next = StBusy;
                end
            end
            StBusy: begin
                if (avl_ready) begin
                    w_complete   = 1'b1;
                    w_state_next = StIdle;
                end
            end
        endcase
    end

    // A port with a pending or in-flight request ignores further valid pulses.
    assign w_cap_i = i_valid && !r_pend_i && !(r_state == StBusy && r_avl_instr);
    assign w_cap_d = d_valid && !r_pend_d && !(r_state == StBusy && !r_avl_instr);

    always_ff @(posedge clock) begin
        if (!reset) begin
            r_state <= StIdle;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_ff @(posedge clock) begin
        if (!reset) begin
            r_pend_i  <= 1'b0;
            r_pend_d  <= 1'b0;
            r_i_addr  <= 32'd0;
            r_d_addr  <= 32'd0;
            r_d_wdata <= 32'd0;
            r_d_wstrb <= 4'd0;
        end else begin
            if (w_cap_i) begin
                r_pend_i <= 1'b1;
                r_i_addr <= i_addr;
            end else if (w_grant_i) begin
                r_pend_i <= 1'b0;
            end
            if (w_cap_d) begin
                r_pend_d  <= 1'b1;
                r_d_addr  <= d_addr;
                r_d_wdata <= d_wdata;
                r_d_wstrb <= d_wstrb;
            end else if (w_grant_d) begin
                r_pend_d <= 1'b0;
            end
        end
    end

    always_ff @(posedge clock) begin
        if (!reset) begin
            r_last_data <= 1'b1;
            r_avl_valid <= 1'b0;
            r_avl_instr <= 1'b0;
            r_avl_addr  <= 32'd0;
            r_avl_wdata <= 32'd0;
            r_avl_wstrb <= 4'd0;
        end else begin
            r_avl_valid <= 1'b0;
            if (w_grant_i) begin
                r_avl_valid <= 1'b1;
                r_avl_instr <= 1'b1;
                r_avl_addr  <= r_i_addr;
                r_avl_wdata <= 32'd0;
                r_avl_wstrb <= 4'd0;
                r_last_data <= 1'b0;
            end else if (w_grant_d) begin
                r_avl_valid <= 1'b1;
                r_avl_instr <= 1'b0;
                r_avl_addr  <= r_d_addr;
                r_avl_wdata <= r_d_wdata;
                r_avl_wstrb <= r_d_wstrb;
                r_last_data <= 1'b1;
            end else if (w_complete) begin
                r_avl_instr <= 1'b0;
                r_avl_addr  <= 32'd0;
                r_avl_wdata <= 32'd0;
                r_avl_wstrb <= 4'd0;
            end
        end
    end

    always_ff @(posedge clock) begin
        if (!reset) begin
            r_i_ready <= 1'b0;
            r_d_ready <= 1'b0;
            r_i_rdata <= 32'd0;
            r_d_rdata <= 32'd0;
        end else begin
            r_i_ready <= w_complete && r_avl_instr;
            r_d_ready <= w_complete && !r_avl_instr;
            r_i_rdata <= (w_complete && r_avl_instr) ? avl_rdata : 32'd0;
            // Stores complete with zero read data.
            r_d_rdata <= (w_complete && !r_avl_instr && r_avl_wstrb == 4'd0) ? avl_rdata : 32'd0;
        end
    end

    assign avl_valid = r_avl_valid;
    assign avl_instr = r_avl_instr;
    assign avl_addr  = r_avl_addr;
    assign avl_wdata = r_avl_wdata;
    assign avl_wstrb = r_avl_wstrb;
    assign i_ready   = r_i_ready;
    assign i_rdata   = r_i_rdata;
    assign d_ready   = r_d_ready;
    assign d_rdata   = r_d_rdata;

endmodule

// File: tb/tb_avl_arbiter.sv
// Bench for avl_arbiter: round-robin (dut0) and data-priority (dut1) instances share request stimulus,
// each with its own bridge responder and a transaction-level reference model.
module tb_avl_arbiter;

    logic        clock = 1'b0;
    logic        reset = 1'b0;
    logic        i_valid = 1'b0;
    logic [31:0] i_addr = 32'd0;
    logic        d_valid = 1'b0;
    logic [31:0] d_addr = 32'd0;
    logic [31:0] d_wdata = 32'd0;
    logic [3:0]  d_wstrb = 4'd0;

    logic        i_ready_w [2];
    logic [31:0] i_rdata_w [2];
    logic        d_ready_w [2];
    logic [31:0] d_rdata_w [2];
    logic        avl_valid_w [2];
    logic        avl_instr_w [2];
    logic [31:0] avl_addr_w [2];
    logic [31:0] avl_wdata_w [2];
    logic [3:0]  avl_wstrb_w [2];
    logic [31:0] avl_rdata_w [2];
    logic        avl_ready_w [2];

    int checks = 0;
    int errors = 0;

    always #5 clock = ~clock;

    avl_arbiter #(.PRIORITY_MODE(0)) u_dut0 (
        .clock(clock), .reset(reset),
        .i_valid(i_valid), .i_addr(i_addr), .i_rdata(i_rdata_w[0]), .i_ready(i_ready_w[0]),
        .d_valid(d_valid), .d_addr(d_addr), .d_wdata(d_wdata), .d_wstrb(d_wstrb),
        .d_rdata(d_rdata_w[0]), .d_ready(d_ready_w[0]),
        .avl_valid(avl_valid_w[0]), .avl_instr(avl_instr_w[0]), .avl_addr(avl_addr_w[0]),
        .avl_wdata(avl_wdata_w[0]), .avl_wstrb(avl_wstrb_w[0]),
        .avl_rdata(avl_rdata_w[0]), .avl_ready(avl_ready_w[0])
    );

    avl_arbiter #(.PRIORITY_MODE(1)) u_dut1 (
        .clock(clock), .reset(reset),
        .i_valid(i_valid), .i_addr(i_addr), .i_rdata(i_rdata_w[1]), .i_ready(i_ready_w[1]),
        .d_valid(d_valid), .d_addr(d_addr), .d_wdata(d_wdata), .d_wstrb(d_wstrb),
        .d_rdata(d_rdata_w[1]), .d_ready(d_ready_w[1]),
        .avl_valid(avl_valid_w[1]), .avl_instr(avl_instr_w[1]), .avl_addr(avl_addr_w[1]),
        .avl_wdata(avl_wdata_w[1]), .avl_wstrb(avl_wstrb_w[1]),
        .avl_rdata(avl_rdata_w[1]), .avl_ready(avl_ready_w[1])
    );

    // Values sampled by the DUTs at each rising edge; cyc numbers the edges.
    int          cyc = 0;
    logic        s_rst = 1'b0;
    logic        s_iv = 1'b0;
    logic        s_dv = 1'b0;
    logic [31:0] s_iaddr = 32'd0;
    logic [31:0] s_daddr = 32'd0;
    logic [31:0] s_dwdata = 32'd0;
    logic [3:0]  s_dwstrb = 4'd0;

    always @(posedge clock) begin
        cyc      <= cyc + 1;
        s_rst    <= reset;
        s_iv     <= i_valid;
        s_dv     <= d_valid;
        s_iaddr  <= i_addr;
        s_daddr  <= d_addr;
        s_dwdata <= d_wdata;
        s_dwstrb <= d_wstrb;
    end

    // Reference model per DUT; port 0 = fetch, port 1 = data.
    bit          m_out [2][2];
    int          m_req [2][2];
    logic [31:0] m_addr [2][2];
    logic [31:0] m_wdata [2];
    logic [3:0]  m_wstrb [2];
    bit          m_busy [2];
    int          m_gport [2];
    logic [31:0] m_gaddr [2];
    logic [31:0] m_gwdata [2];
    logic [3:0]  m_gwstrb [2];
    int          m_free [2];
    int          m_last [2];

    bit          b_busy [2];
    int          b_cnt [2];
    bit          b_done [2];
    logic [31:0] b_rdata [2];

    int          g_port_log [2][$];
    int          g_cyc_log [2][$];
    int          irdy_cyc [2];

    int          br_lat = -1;
    bit          br_fixed = 1'b0;
    logic [31:0] br_data = 32'd0;
    bit          br_stray = 1'b0;
    bit          rnd_stray = 1'b0;

    always @(negedge clock) begin
        for (int d = 0; d < 2; d++) begin
            bit          el_i;
            bit          el_d;
            bit          ei;
            int          w;
            logic [31:0] wd;
            logic [3:0]  ws;
            logic [31:0] exp_rd;
            if (!s_rst) begin
                m_out[d][0] = 1'b0;
                m_out[d][1] = 1'b0;
                m_busy[d]   = 1'b0;
                m_free[d]   = cyc + 1;
                m_last[d]   = 1;
                b_busy[d]   = 1'b0;
                b_done[d]   = 1'b0;
                avl_ready_w[d] = 1'b0;
                avl_rdata_w[d] = 32'd0;
                checks++;
                if (i_ready_w[d] !== 1'b0 || d_ready_w[d] !== 1'b0 || avl_valid_w[d] !== 1'b0 ||
                    avl_instr_w[d] !== 1'b0 || avl_addr_w[d] !== 32'd0 ||
                    avl_wdata_w[d] !== 32'd0 || avl_wstrb_w[d] !== 4'd0 ||
                    i_rdata_w[d] !== 32'd0 || d_rdata_w[d] !== 32'd0) begin
                    errors++;
                    $display("FAIL reset_outputs dut%0d cyc %0d: irdy=%b drdy=%b valid=%b addr=%h, want all 0",
                             d, cyc, i_ready_w[d], d_ready_w[d], avl_valid_w[d], avl_addr_w[d]);
                end
            end else begin
                if (s_iv && !m_out[d][0]) begin
                    m_out[d][0]  = 1'b1;
                    m_req[d][0]  = cyc;
                    m_addr[d][0] = s_iaddr;
                end
                if (s_dv && !m_out[d][1]) begin
                    m_out[d][1]  = 1'b1;
                    m_req[d][1]  = cyc;
                    m_addr[d][1] = s_daddr;
                    m_wdata[d]   = s_dwdata;
                    m_wstrb[d]   = s_dwstrb;
                end

                checks++;
                if (b_done[d]) begin
                    ei     = (m_gport[d] == 0);
                    exp_rd = (!ei && m_gwstrb[d] != 4'd0) ? 32'd0 : b_rdata[d];
                    if (i_ready_w[d] !== ei || d_ready_w[d] !== !ei ||
                        (ei && i_rdata_w[d] !== exp_rd) || (!ei && d_rdata_w[d] !== exp_rd)) begin
                        errors++;
                        $display("FAIL completion dut%0d cyc %0d: irdy=%b drdy=%b irdata=%h drdata=%h, want irdy=%b drdy=%b rdata=%h",
                                 d, cyc, i_ready_w[d], d_ready_w[d], i_rdata_w[d], d_rdata_w[d],
                                 ei, !ei, exp_rd);
                    end
                    m_out[d][m_gport[d]] = 1'b0;
                    m_busy[d] = 1'b0;
                    m_free[d] = cyc + 1;
                    if (ei) irdy_cyc[d] = cyc;
                    b_done[d] = 1'b0;
                end else if (i_ready_w[d] !== 1'b0 || d_ready_w[d] !== 1'b0) begin
                    errors++;
                    $display("FAIL spurious_ready dut%0d cyc %0d: irdy=%b drdy=%b, want 0 0",
                             d, cyc, i_ready_w[d], d_ready_w[d]);
                end

                el_i = m_out[d][0] && (m_req[d][0] < cyc);
                el_d = m_out[d][1] && (m_req[d][1] < cyc);
                checks++;
                if (!m_busy[d] && cyc >= m_free[d] && (el_i || el_d)) begin
                    if (el_i && el_d) w = (d == 1) ? 1 : ((m_last[d] == 1) ? 0 : 1);
                    else w = el_i ? 0 : 1;
                    wd = (w == 1) ? m_wdata[d] : 32'd0;
                    ws = (w == 1) ? m_wstrb[d] : 4'd0;
                    if (avl_valid_w[d] !== 1'b1 || avl_instr_w[d] !== (w == 0) ||
                        avl_addr_w[d] !== m_addr[d][w] || avl_wdata_w[d] !== wd ||
                        avl_wstrb_w[d] !== ws) begin
                        errors++;
                        $display("FAIL grant dut%0d cyc %0d: valid=%b instr=%b addr=%h wdata=%h wstrb=%h, want 1 %b %h %h %h",
                                 d, cyc, avl_valid_w[d], avl_instr_w[d], avl_addr_w[d],
                                 avl_wdata_w[d], avl_wstrb_w[d], (w == 0), m_addr[d][w], wd, ws);
                    end
                    m_busy[d]   = 1'b1;
                    m_gport[d]  = w;
                    m_last[d]   = w;
                    m_gaddr[d]  = m_addr[d][w];
                    m_gwdata[d] = wd;
                    m_gwstrb[d] = ws;
                    g_port_log[d].push_back(w);
                    g_cyc_log[d].push_back(cyc);
                    b_busy[d] = 1'b1;
                    b_cnt[d]  = (br_lat < 0) ? int'($urandom_range(0, 3)) : br_lat;
                end else if (m_busy[d]) begin
                    if (avl_valid_w[d] !== 1'b0 || avl_instr_w[d] !== (m_gport[d] == 0) ||
                        avl_addr_w[d] !== m_gaddr[d] || avl_wdata_w[d] !== m_gwdata[d] ||
                        avl_wstrb_w[d] !== m_gwstrb[d]) begin
                        errors++;
                        $display("FAIL busy_hold dut%0d cyc %0d: valid=%b instr=%b addr=%h, want 0 %b %h",
                                 d, cyc, avl_valid_w[d], avl_instr_w[d], avl_addr_w[d],
                                 (m_gport[d] == 0), m_gaddr[d]);
                    end
                end else if (avl_valid_w[d] !== 1'b0 || avl_instr_w[d] !== 1'b0 ||
                             avl_addr_w[d] !== 32'd0 || avl_wdata_w[d] !== 32'd0 ||
                             avl_wstrb_w[d] !== 4'd0) begin
                    errors++;
                    $display("FAIL idle_outputs dut%0d cyc %0d: valid=%b instr=%b addr=%h, want all 0",
                             d, cyc, avl_valid_w[d], avl_instr_w[d], avl_addr_w[d]);
                end

                avl_ready_w[d] = 1'b0;
                if (b_busy[d]) begin
                    if (b_cnt[d] == 0) begin
                        b_rdata[d]     = br_fixed ? br_data : $urandom;
                        avl_rdata_w[d] = b_rdata[d];
                        avl_ready_w[d] = 1'b1;
                        b_busy[d]      = 1'b0;
                        b_done[d]      = 1'b1;
                    end else begin
                        b_cnt[d] = b_cnt[d] - 1;
                    end
                end else if (br_stray || (rnd_stray && $urandom_range(0, 7) == 0)) begin
                    avl_rdata_w[d] = $urandom;
                    avl_ready_w[d] = 1'b1;
                end
            end
        end
    end

    task automatic tick();
        @(negedge clock);
        #1;
    endtask

    task automatic pulse(input bit fi, input logic [31:0] ia, input bit fd, input logic [31:0] da,
                         input logic [31:0] wd, input logic [3:0] ws);
        i_valid = fi;
        i_addr  = ia;
        d_valid = fd;
        d_addr  = da;
        d_wdata = wd;
        d_wstrb = ws;
        tick();
        i_valid = 1'b0;
        d_valid = 1'b0;
    endtask

    task automatic wait_idle(input string tag);
        int n = 0;
        while ((m_busy[0] || m_busy[1] || m_out[0][0] || m_out[0][1] || m_out[1][0] ||
                m_out[1][1]) && n < 200) begin
            tick();
            n++;
        end
        checks++;
        if (n >= 200) begin
            errors++;
            $display("FAIL %s_timeout: still busy after %0d cycles, want idle", tag, n);
        end
    endtask

    task automatic clear_logs();
        for (int d = 0; d < 2; d++) begin
            g_port_log[d].delete();
            g_cyc_log[d].delete();
        end
    endtask

    task automatic test_reset();
        reset = 1'b0;
        tick();
        tick();
        for (int d = 0; d < 2; d++) begin
            checks++;
            if (avl_valid_w[d] !== 1'b0 || i_ready_w[d] !== 1'b0 || d_ready_w[d] !== 1'b0 ||
                avl_addr_w[d] !== 32'd0) begin
                errors++;
                $display("FAIL test_reset dut%0d: valid=%b irdy=%b drdy=%b addr=%h, want 0",
                         d, avl_valid_w[d], i_ready_w[d], d_ready_w[d], avl_addr_w[d]);
            end
        end
        reset = 1'b1;
        tick();
        clear_logs();
    endtask

    task automatic test_fetch_only();
        int          vcnt = 0;
        int          vfirst = -1;
        int          rcnt = 0;
        int          rfirst = -1;
        int          dcnt = 0;
        logic        vinstr = 1'b0;
        logic [31:0] vaddr = 32'd0;
        logic [31:0] rdat = 32'd0;
        br_lat   = 3;
        br_fixed = 1'b1;
        br_data  = 32'hDEADBEEF;
        pulse(1'b1, 32'h100, 1'b0, 32'd0, 32'd0, 4'd0);
        for (int t = 0; t < 12; t++) begin
            if (avl_valid_w[0]) begin
                vcnt++;
                if (vfirst < 0) begin
                    vfirst = t;
                    vinstr = avl_instr_w[0];
                    vaddr  = avl_addr_w[0];
                end
            end
            if (i_ready_w[0]) begin
                rcnt++;
                if (rfirst < 0) begin
                    rfirst = t;
                    rdat   = i_rdata_w[0];
                end
            end
            if (d_ready_w[0]) dcnt++;
            tick();
        end
        checks++;
        if (vfirst != 1 || vcnt != 1) begin
            errors++;
            $display("FAIL fetch_avl_valid: first=%0d count=%0d, want 1 1", vfirst, vcnt);
        end
        checks++;
        if (vinstr !== 1'b1 || vaddr !== 32'h100) begin
            errors++;
            $display("FAIL fetch_fields: instr=%b addr=%h, want 1 00000100", vinstr, vaddr);
        end
        checks++;
        if (rfirst != 5 || rcnt != 1 || rdat !== 32'hDEADBEEF) begin
            errors++;
            $display("FAIL fetch_ready: first=%0d count=%0d rdata=%h, want 5 1 deadbeef",
                     rfirst, rcnt, rdat);
        end
        checks++;
        if (dcnt != 0) begin
            errors++;
            $display("FAIL fetch_no_dready: count=%0d, want 0", dcnt);
        end
        wait_idle("fetch");
    endtask

    task automatic test_store();
        int          vfirst = -1;
        int          rfirst = -1;
        logic        vinstr = 1'b1;
        logic [3:0]  vstrb = 4'd0;
        logic [31:0] vwdata = 32'd0;
        logic [31:0] rdat = 32'hFFFFFFFF;
        br_lat   = 1;
        br_fixed = 1'b1;
        br_data  = 32'hCAFEF00D;
        pulse(1'b0, 32'd0, 1'b1, 32'h2004, 32'h12345678, 4'h3);
        for (int t = 0; t < 10; t++) begin
            if (avl_valid_w[0] && vfirst < 0) begin
                vfirst = t;
                vinstr = avl_instr_w[0];
                vstrb  = avl_wstrb_w[0];
                vwdata = avl_wdata_w[0];
            end
            if (d_ready_w[0] && rfirst < 0) begin
                rfirst = t;
                rdat   = d_rdata_w[0];
            end
            tick();
        end
        checks++;
        if (vfirst != 1 || vinstr !== 1'b0 || vstrb !== 4'h3 || vwdata !== 32'h12345678) begin
            errors++;
            $display("FAIL store_fields: first=%0d instr=%b wstrb=%h wdata=%h, want 1 0 3 12345678",
                     vfirst, vinstr, vstrb, vwdata);
        end
        checks++;
        if (rfirst != 3 || rdat !== 32'd0) begin
            errors++;
            $display("FAIL store_ready: first=%0d rdata=%h, want 3 00000000", rfirst, rdat);
        end
        wait_idle("store");
    endtask

    task automatic test_tie();
        test_reset();
        br_lat   = 1;
        br_fixed = 1'b0;
        pulse(1'b1, 32'h1000, 1'b1, 32'h2000, 32'hA5A5A5A5, 4'h0);
        wait_idle("tie1");
        checks++;
        if (g_port_log[0].size() != 2 || g_port_log[0][0] != 0 || g_port_log[0][1] != 1) begin
            errors++;
            $display("FAIL tie_rr_first: order size=%0d, want fetch then data", g_port_log[0].size());
        end
        checks++;
        if (g_port_log[1].size() != 2 || g_port_log[1][0] != 1 || g_port_log[1][1] != 0) begin
            errors++;
            $display("FAIL tie_prio_first: order size=%0d, want data then fetch", g_port_log[1].size());
        end
        pulse(1'b1, 32'h1100, 1'b0, 32'd0, 32'd0, 4'd0);
        wait_idle("tie_fetch");
        clear_logs();
        pulse(1'b1, 32'h1200, 1'b1, 32'h2200, 32'h5A5A5A5A, 4'hC);
        wait_idle("tie2");
        checks++;
        if (g_port_log[0].size() != 2 || g_port_log[0][0] != 1 || g_port_log[0][1] != 0) begin
            errors++;
            $display("FAIL tie_rr_alternate: order size=%0d, want data then fetch", g_port_log[0].size());
        end
        checks++;
        if (g_port_log[1].size() != 2 || g_port_log[1][0] != 1) begin
            errors++;
            $display("FAIL tie_prio_repeat: order size=%0d, want data first", g_port_log[1].size());
        end
    endtask

    task automatic test_back_to_back();
        clear_logs();
        br_lat = 4;
        pulse(1'b1, 32'h500, 1'b0, 32'd0, 32'd0, 4'd0);
        tick();
        pulse(1'b0, 32'd0, 1'b1, 32'h600, 32'd0, 4'd0);
        wait_idle("b2b");
        for (int d = 0; d < 2; d++) begin
            checks++;
            if (g_port_log[d].size() != 2 || g_port_log[d][1] != 1 ||
                g_cyc_log[d][1] - irdy_cyc[d] != 1) begin
                errors++;
                $display("FAIL b2b_gap dut%0d: grants=%0d gap=%0d, want 2 grants gap 1", d,
                         g_port_log[d].size(),
                         (g_cyc_log[d].size() > 1) ? g_cyc_log[d][1] - irdy_cyc[d] : -1);
            end
        end
    endtask

    task automatic test_reset_mid();
        int rcnt = 0;
        int n0;
        int mark;
        br_lat = 6;
        pulse(1'b1, 32'h300, 1'b0, 32'd0, 32'd0, 4'd0);
        tick();
        checks++;
        if (avl_instr_w[0] !== 1'b1 || avl_addr_w[0] !== 32'h300) begin
            errors++;
            $display("FAIL rstmid_inflight: instr=%b addr=%h, want 1 00000300",
                     avl_instr_w[0], avl_addr_w[0]);
        end
        reset = 1'b0;
        tick();
        reset = 1'b1;
        checks++;
        if (avl_instr_w[0] !== 1'b0 || avl_addr_w[0] !== 32'd0 || i_ready_w[0] !== 1'b0) begin
            errors++;
            $display("FAIL rstmid_cleared: instr=%b addr=%h irdy=%b, want 0",
                     avl_instr_w[0], avl_addr_w[0], i_ready_w[0]);
        end
        br_stray = 1'b1;
        tick();
        br_stray = 1'b0;
        for (int t = 0; t < 8; t++) begin
            if (i_ready_w[0] || d_ready_w[0] || i_ready_w[1] || d_ready_w[1]) rcnt++;
            tick();
        end
        checks++;
        if (rcnt != 0) begin
            errors++;
            $display("FAIL rstmid_no_ready: ready cycles=%0d, want 0", rcnt);
        end
        n0   = g_port_log[0].size();
        mark = cyc;
        br_lat = 1;
        pulse(1'b1, 32'h400, 1'b0, 32'd0, 32'd0, 4'd0);
        wait_idle("rstmid_after");
        checks++;
        if (g_port_log[0].size() != n0 + 1 || irdy_cyc[0] <= mark) begin
            errors++;
            $display("FAIL rstmid_recover: grants=%0d ready_cyc=%0d, want %0d and > %0d",
                     g_port_log[0].size(), irdy_cyc[0], n0 + 1, mark);
        end
    endtask

    task automatic test_random();
        clear_logs();
        br_lat    = -1;
        br_fixed  = 1'b0;
        rnd_stray = 1'b1;
        for (int t = 0; t < 1500; t++) begin
            i_valid = !m_out[0][0] && !m_out[1][0] && ($urandom_range(0, 2) == 0);
            i_addr  = $urandom;
            d_valid = !m_out[0][1] && !m_out[1][1] && ($urandom_range(0, 2) == 0);
            d_addr  = $urandom;
            d_wdata = $urandom;
            d_wstrb = ($urandom_range(0, 1) == 0) ? 4'd0 : 4'($urandom_range(1, 15));
            tick();
        end
        i_valid   = 1'b0;
        d_valid   = 1'b0;
        rnd_stray = 1'b0;
        wait_idle("random");
        checks++;
        if (g_port_log[0].size() < 100 || g_port_log[1].size() < 100) begin
            errors++;
            $display("FAIL random_activity: grants=%0d/%0d, want >= 100 each",
                     g_port_log[0].size(), g_port_log[1].size());
        end
    endtask

    initial begin
        tick();
        test_reset();
        test_fetch_only();
        test_store();
        test_tie();
        test_back_to_back();
        test_reset_mid();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
